// File: rtl/ln_input_pkg.sv
// rtl/ln_input_pkg.sv - shared types, defaults and helpers for the LogicNet input stage
package ln_input_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } ln_in_state_e;

    localparam int LN_N_PIXELS = 784;
    localparam int LN_PIX_W    = 8;
    localparam int LN_IN_BITS  = 1;

    function automatic int ln_frame_w(input int n, input int b);
        return n * b;
    endfunction

endpackage

// File: rtl/ln_pixel_quant.sv
// rtl/ln_pixel_quant.sv - combinational raw pixel to IN_BITS quantizer (MSB truncation)
module ln_pixel_quant
    import ln_input_pkg::*;
#(
    parameter int PIX_W   = LN_PIX_W,
    parameter int IN_BITS = LN_IN_BITS
) (
    input  logic [PIX_W-1:0]   pixel,
    output logic [IN_BITS-1:0] q
);

    // Keep the top IN_BITS bits; no rounding so that a rounding mode can be added here later
    assign q = IN_BITS'(pixel >> (PIX_W - IN_BITS));

endmodule

// File: rtl/logicnet_input_deserializer.sv
// rtl/logicnet_input_deserializer.sv - pixel stream to frame vector; LN_IN_DBLBUF_EN adds a second frame slot
module logicnet_input_deserializer
    import ln_input_pkg::*;
#(
    parameter int N_PIXELS = LN_N_PIXELS,
    parameter int PIX_W    = LN_PIX_W,
    parameter int IN_BITS  = LN_IN_BITS,
    parameter int CNT_W    = 10
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        s_valid,
    output logic                                        s_ready,
    input  logic [PIX_W-1:0]                            s_pixel,
    input  logic                                        s_last,
    output logic                                        m_valid,
    input  logic                                        m_ready,
    output logic [ln_frame_w(N_PIXELS, IN_BITS)-1:0]    m_data,
    output logic                                        err_frame
);

    localparam int FRAME_W = ln_frame_w(N_PIXELS, IN_BITS);

    logic [IN_BITS-1:0] pix_q;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] shift_next;
    logic [CNT_W-1:0]   count;
    logic               xfer;
    logic               at_end;
    logic               frame_ok;
    logic               frame_bad;
    logic               ready_en;

    ln_pixel_quant #(
        .PIX_W   (PIX_W),
        .IN_BITS (IN_BITS)
    ) u_quant (
        .pixel (s_pixel),
        .q     (pix_q)
    );

    // New pixel enters at the top; after N_PIXELS shifts pixel 0 lands at the LSBs
    assign shift_next = FRAME_W'({pix_q, shreg} >> IN_BITS);

    assign xfer      = s_valid && s_ready;
    assign at_end    = (count == CNT_W'(N_PIXELS - 1));
    assign frame_ok  = xfer && at_end && s_last;
    assign frame_bad = xfer && (at_end != s_last);

    // Pixel counter, assembly shift register and the mismatch error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            shreg     <= '0;
            err_frame <= 1'b0;
        end else begin
            err_frame <= frame_bad;
            if (xfer) begin
                if (frame_ok || frame_bad) begin
                    count <= '0;
                end else begin
                    count <= count + CNT_W'(1);
                end
                shreg <= frame_bad ? '0 : shift_next;
            end
        end
    end

`ifdef LN_IN_DBLBUF_EN

    logic fill_done;
    logic out_free;

    assign out_free = !m_valid || m_ready;
    assign s_ready  = ready_en && !fill_done;

    // Two slots: a completed fill buffer advances to m_data whenever the output slot is free or being consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en  <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            fill_done <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (frame_ok && out_free) begin
                m_data  <= shift_next;
                m_valid <= 1'b1;
            end else if (frame_ok) begin
                fill_done <= 1'b1;
            end else if (fill_done && out_free) begin
                m_data    <= shreg;
                m_valid   <= 1'b1;
                fill_done <= 1'b0;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

`else

    localparam logic [0:0] ST_FILL = 1'(FILL);
    localparam logic [0:0] ST_HOLD = 1'(HOLD);

    logic [0:0] state;

    assign s_ready = ready_en;

    // FILL accepts pixels until a well-formed frame completes; HOLD presents it until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_FILL;
            ready_en <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    ready_en <= 1'b1;
                    if (frame_ok) begin
                        m_data   <= shift_next;
                        m_valid  <= 1'b1;
                        ready_en <= 1'b0;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        m_valid  <= 1'b0;
                        ready_en <= 1'b1;
                        state    <= ST_FILL;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_logicnet_input_deserializer.sv
// tb/tb_logicnet_input_deserializer.sv - self-checking bench for logicnet_input_deserializer
module tb_logicnet_input_deserializer;

    localparam int N  = 4;
    localparam int PW = 8;
    localparam int IB = 2;
    localparam int FW = N * IB;
    localparam int CW = 3;
`ifdef LN_IN_DBLBUF_EN
    localparam int SLOTS = 2;
`else
    localparam int SLOTS = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [PW-1:0] s_pixel = '0;
    logic          s_last = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [FW-1:0] m_data;
    logic          err_frame;

    always #5 clk = ~clk;

    logicnet_input_deserializer #(
        .N_PIXELS (N),
        .PIX_W    (PW),
        .IN_BITS  (IB),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_pixel   (s_pixel),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .err_frame (err_frame)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: partial frame as a list of quantized pixels, completed frames as a queue
    logic [IB-1:0] cur[$];
    logic [FW-1:0] pend[$];
    bit            ready_en = 1'b0;
    bit            err_exp = 1'b0;
    logic [FW-1:0] mdata_exp = '0;

    function automatic bit exp_sready();
        return ready_en && (pend.size() < SLOTS);
    endfunction

    task automatic model_reset();
        cur.delete();
        pend.delete();
        ready_en  = 1'b0;
        err_exp   = 1'b0;
        mdata_exp = '0;
    endtask

    task automatic model_edge();
        bit            xfer;
        bit            consume;
        logic [FW-1:0] f;
        xfer    = s_valid && exp_sready();
        consume = (pend.size() > 0) && m_ready;
        err_exp = 1'b0;
        if (consume) void'(pend.pop_front());
        if (xfer) begin
            cur.push_back(s_pixel[PW-1 -: IB]);
            if ((cur.size() == N) != s_last) begin
                err_exp = 1'b1;
                cur.delete();
            end else if (cur.size() == N) begin
                f = '0;
                foreach (cur[k]) f[k*IB +: IB] = cur[k];
                pend.push_back(f);
                cur.delete();
            end
        end
        if (pend.size() > 0) mdata_exp = pend[0];
        ready_en = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".s_ready"},   32'(s_ready),   32'(exp_sready()));
        check({tag, ".m_valid"},   32'(m_valid),   32'(pend.size() > 0));
        check({tag, ".err_frame"}, 32'(err_frame), 32'(err_exp));
        check({tag, ".m_data"},    32'(m_data),    32'(mdata_exp));
    endtask

    // Drive one cycle of inputs (at the falling edge), advance, and compare mid-cycle
    task automatic cyc(input string tag, input bit v, input logic [PW-1:0] p, input bit l, input bit mr);
        s_valid = v;
        s_pixel = p;
        s_last  = l;
        m_ready = mr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(tag);
    endtask

    // A pixel whose s_last follows the model's own position in the frame
    task automatic auto_pix(input string tag, input bit v, input bit mr);
        cyc(tag, v, PW'($urandom), (cur.size() == N - 1), mr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        model_reset();
        #1;
        check("rst.async.s_ready", 32'(s_ready), 32'd0);
        check("rst.async.m_valid", 32'(m_valid), 32'd0);
        check("rst.async.m_data",  32'(m_data),  32'd0);
        check("rst.async.err",     32'(err_frame), 32'd0);
        repeat (2) @(negedge clk);
        check("rst.hold.s_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
    endtask

    logic [PW-1:0] t1_pix [4] = '{8'h40, 8'h80, 8'hC0, 8'hFF};

    initial begin
        // Reset state
        @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;
        cyc("rise", 1'b0, '0, 1'b0, 1'b0);

        // Directed frame with known packing, consumer always ready
        for (int i = 0; i < 4; i++) cyc("t1", 1'b1, t1_pix[i], (i == 3), 1'b1);
        check("t1.packed", 32'(m_data), 32'h0000_00F9);
        repeat (2) cyc("t1.idle", 1'b0, '0, 1'b0, 1'b1);

        // Same frame held for 10 cycles with the source still offering pixels
        for (int i = 0; i < 4; i++) cyc("t2", 1'b1, t1_pix[i], (i == 3), 1'b0);
        repeat (10) auto_pix("t2.hold", 1'b1, 1'b0);
        repeat (6) auto_pix("t2.drain", 1'b1, 1'b1);
        repeat (3) cyc("t2.idle", 1'b0, '0, 1'b0, 1'b1);

        // Early s_last on the 2nd pixel, then a good frame
        cyc("t3", 1'b1, 8'h12, 1'b0, 1'b1);
        cyc("t3", 1'b1, 8'h34, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) auto_pix("t3.next", 1'b1, 1'b1);
        repeat (2) cyc("t3.idle", 1'b0, '0, 1'b0, 1'b1);

        // Missing s_last on the 4th pixel
        for (int i = 0; i < 4; i++) cyc("t4", 1'b1, PW'($urandom), 1'b0, 1'b1);
        repeat (2) cyc("t4.idle", 1'b0, '0, 1'b0, 1'b1);

        // Reset after two pixels, then a clean frame
        cyc("t5", 1'b1, 8'hFF, 1'b0, 1'b1);
        cyc("t5", 1'b1, 8'hFF, 1'b0, 1'b1);
        do_reset();
        cyc("t5.rise", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc("t5.frame", 1'b1, 8'h00 + 8'(i * 8'h40), (i == 3), 1'b1);
        repeat (2) cyc("t5.idle", 1'b0, '0, 1'b0, 1'b1);

        // Two frames streamed back to back with a ready consumer
        for (int i = 0; i < 8; i++) auto_pix("t6", 1'b1, 1'b1);
        repeat (3) cyc("t6.idle", 1'b0, '0, 1'b0, 1'b1);

        // Randomized traffic with occasional s_last errors and backpressure
        for (int i = 0; i < 600; i++) begin
            cyc("rand", ($urandom_range(0, 4) != 0), PW'($urandom),
                ((cur.size() == N - 1) ^ ($urandom_range(0, 19) == 0)),
                ($urandom_range(0, 3) != 0));
            if (i == 300) begin
                do_reset();
                cyc("rand.rise", 1'b0, '0, 1'b0, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
